// File: rtl/avalon_mem_master.sv
// avalon_mem_master: turns one CPU load/store request into a single Avalon-MM
// read or write. It holds the command across waitrequest stalls, builds
// byteenable and lane-replicated writedata, and returns extended load data.
// Ports:
//   clk, reset                        clock, async active-high reset
//   req_valid/req_ready               CPU request handshake (ready only in IDLE)
//   req_write/req_size/req_signed     operation, 00 byte 01 half 10 word, sign-extend loads
//   req_addr/req_wdata                byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_error  one-cycle completion with load data / error
//   address/read/write/writedata/byteenable/waitrequest/readdata  Avalon-MM master
module avalon_mem_master #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_CAPT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               op_write_q, op_write_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic [1:0]         lane_q, lane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               read_q, read_d, write_q, write_d;
  logic [31:0]        address_q, address_d, writedata_q, writedata_d;
  logic [3:0]         byteenable_q, byteenable_d;
  logic               resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;

  logic               accept_c, misaligned_c, timeout_c;
  logic [3:0]         be_c;
  logic [31:0]        wd_c, load_c;
  logic [7:0]         lane_byte_c;
  logic [15:0]        lane_half_c;

  // Request decode: alignment check, lane enables and replicated store data.
  always_comb begin
    accept_c = req_valid && ready_q;
    unique case (req_size)
      2'b00: begin
        misaligned_c = 1'b0;
        be_c         = 4'b0001 << req_addr[1:0];
        wd_c         = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned_c = req_addr[0];
        be_c         = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_c         = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned_c = |req_addr[1:0];
        be_c         = 4'b1111;
        wd_c         = req_wdata;
      end
      default: begin
        misaligned_c = 1'b1;
        be_c         = 4'b0000;
        wd_c         = 32'd0;
      end
    endcase
  end

  // Timeout fires on the stalled edge that brings the count to WAIT_LIMIT.
  always_comb begin
    timeout_c = (WAIT_LIMIT != 0) && waitrequest &&
                (cnt_q == CNT_W'(WAIT_LIMIT - 1));
  end

  // Little-endian lane extraction and sign/zero extension of load data.
  always_comb begin
    unique case (lane_q)
      2'd0:    lane_byte_c = readdata[7:0];
      2'd1:    lane_byte_c = readdata[15:8];
      2'd2:    lane_byte_c = readdata[23:16];
      default: lane_byte_c = readdata[31:24];
    endcase
    lane_half_c = lane_q[1] ? readdata[31:16] : readdata[15:0];
    unique case (size_q)
      2'b00:   load_c = signed_q ? {{24{lane_byte_c[7]}}, lane_byte_c} : {24'd0, lane_byte_c};
      2'b01:   load_c = signed_q ? {{16{lane_half_c[15]}}, lane_half_c} : {16'd0, lane_half_c};
      default: load_c = readdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = misaligned_c ? S_RESP : S_BUS;
      S_BUS: begin
        if (!waitrequest)   state_d = op_write_q ? S_RESP : S_CAPT;
        else if (timeout_c) state_d = S_RESP;
      end
      S_CAPT:  state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; strobes and pulses default low.
  always_comb begin
    op_write_d   = op_write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    ready_d      = 1'b0;
    read_d       = 1'b0;
    write_d      = 1'b0;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    resp_valid_d = 1'b0;
    resp_error_d = resp_error_q;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept_c) begin
          op_write_d   = req_write;
          size_d       = req_size;
          signed_d     = req_signed;
          lane_d       = req_addr[1:0];
          cnt_d        = '0;
          ready_d      = 1'b0;
          resp_rdata_d = 32'd0;
          resp_error_d = misaligned_c;
          if (misaligned_c) begin
            resp_valid_d = 1'b1;
          end else begin
            read_d       = !req_write;
            write_d      = req_write;
            address_d    = {req_addr[31:2], 2'b00};
            writedata_d  = wd_c;
            byteenable_d = be_c;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          resp_valid_d = op_write_q;
        end else if (timeout_c) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else begin
          read_d  = read_q;
          write_d = write_q;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_CAPT: begin
        resp_rdata_d = load_c;
        resp_valid_d = 1'b1;
      end
      default: ready_d = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_write_q   <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'd0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      op_write_q   <= op_write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign read       = read_q;
  assign write      = write_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_avalon_mem_master.sv
// Directed bench for avalon_mem_master with a small byte-lane RAM model.
module tb_avalon_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int          passed = 0;
  int          total  = 0;
  int          stall_set = 0;
  logic        stuck = 1'b0;
  int          seen;
  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  avalon_mem_master #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  // Stall for stall_set cycles of each strobe burst, or forever when stuck.
  assign waitrequest = (read || write) && (stuck || (seen < stall_set));

  always @(posedge clk or posedge reset) begin
    if (reset)                seen <= 0;
    else if (!(read || write)) seen <= 0;
    else if (waitrequest)     seen <= seen + 1;
  end

  // RAM: read data appears after the accepting edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      readdata <= 32'd0;
    end else if (!waitrequest) begin
      if (write)
        for (int i = 0; i < 4; i++)
          if (byteenable[i]) mem[address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
      if (read) readdata <= mem[address[5:2]];
    end
  end

  // Issue one request and observe it until resp_valid (bounded).
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int rd_n, output int wr_n, output logic [31:0] a_f,
                        output logic [3:0] be_f, output logic [31:0] wd_f,
                        output logic stable, output logic rv_after);
    int w;
    lat = -1; rdata = 32'hDEAD_BEEF; err = 1'bx; rd_n = 0; wr_n = 0;
    a_f = 32'hX; be_f = 4'hX; wd_f = 32'hX; stable = 1'b1; rv_after = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (read)  rd_n++;
      if (write) wr_n++;
      if (read || write) begin
        if (rd_n + wr_n == 1) begin a_f = address; be_f = byteenable; wd_f = writedata; end
        else if (address !== a_f || byteenable !== be_f || writedata !== wd_f) stable = 1'b0;
      end
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; err = resp_error;
        @(negedge clk); rv_after = resp_valid;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h1;
    repeat (3) @(negedge clk);
    total++;
    if ({read, write, resp_valid, resp_error} !== 4'b0000) $display("FAIL reset_strobes got %b want 0000", {read, write, resp_valid, resp_error});
    else passed++;
    total++;
    if ({address, writedata, resp_rdata} !== 96'd0 || byteenable !== 4'd0) $display("FAIL reset_data addr=%h wd=%h rd=%h be=%b want all 0", address, writedata, resp_rdata, byteenable);
    else passed++;
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else passed++;
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (read !== 1'b0 || write !== 1'b0 || req_ready !== 1'b1) $display("FAIL reset_noaccept rd=%b wr=%b rdy=%b want 0 0 1", read, write, req_ready);
    else passed++;
  endtask

  task automatic test_store_word();
    int lat, rn, wn; logic [31:0] rd, af, wdf; logic er, st, rva; logic [3:0] bef;
    do_req(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h1234_5678, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (lat !== 2 || er !== 1'b0 || rva !== 1'b0) $display("FAIL sw_resp lat=%0d err=%b next=%b want 2 0 0", lat, er, rva);
    else passed++;
    total++;
    if (wn !== 1 || rn !== 0) $display("FAIL sw_strobes wr=%0d rd=%0d want 1 0", wn, rn);
    else passed++;
    total++;
    if (af !== 32'h8000_0010 || bef !== 4'b1111 || wdf !== 32'h1234_5678) $display("FAIL sw_cmd a=%h be=%b wd=%h want 80000010 1111 12345678", af, bef, wdf);
    else passed++;
  endtask

  task automatic test_store_byte_half();
    int lat, rn, wn; logic [31:0] rd, af, wdf; logic er, st, rva; logic [3:0] bef;
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00AB, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (af !== 32'h0 || bef !== 4'b1000 || wdf !== 32'hABAB_ABAB || lat !== 2) $display("FAIL sb_cmd a=%h be=%b wd=%h lat=%0d want 0 1000 abababab 2", af, bef, wdf, lat);
    else passed++;
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'hAB00_0000 || lat !== 3 || rn !== 1 || er !== 1'b0) $display("FAIL lw_after_sb data=%h lat=%0d rd=%0d err=%b want ab000000 3 1 0", rd, lat, rn, er);
    else passed++;
    total++;
    if (bef !== 4'b1111 || wn !== 0) $display("FAIL lw_cmd be=%b wr=%0d want 1111 0", bef, wn);
    else passed++;
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0026, 32'h1111_BEEF, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (af !== 32'h24 || bef !== 4'b1100 || wdf !== 32'hBEEF_BEEF) $display("FAIL sh_cmd a=%h be=%b wd=%h want 24 1100 beefbeef", af, bef, wdf);
    else passed++;
  endtask

  task automatic test_loads();
    int lat, rn, wn; logic [31:0] rd, af, wdf; logic er, st, rva; logic [3:0] bef;
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0080_FF00, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    do_req(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'hFFFF_FF80 || bef !== 4'b0100) $display("FAIL lb_signed data=%h be=%b want ffffff80 0100", rd, bef);
    else passed++;
    do_req(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'h0000_0080) $display("FAIL lbu data=%h want 00000080", rd);
    else passed++;
    do_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'h0000_0080 || bef !== 4'b1100) $display("FAIL lh_hi data=%h be=%b want 00000080 1100", rd, bef);
    else passed++;
    do_req(1'b0, 2'b01, 1'b1, 32'h0, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'hFFFF_FF00) $display("FAIL lh_lo_signed data=%h want ffffff00", rd);
    else passed++;
    do_req(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'h0000_FF00) $display("FAIL lhu_lo data=%h want 0000ff00", rd);
    else passed++;
    do_req(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'hFFFF_FFFF || bef !== 4'b0010) $display("FAIL lb_lane1 data=%h be=%b want ffffffff 0010", rd, bef);
    else passed++;
  endtask

  task automatic test_wait_states();
    int lat, rn, wn; logic [31:0] rd, af, wdf; logic er, st, rva; logic [3:0] bef;
    stall_set = 3;
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    stall_set = 0;
    total++;
    if (rn !== 4 || st !== 1'b1 || af !== 32'h0) $display("FAIL lw_stall_read cycles=%0d stable=%b a=%h want 4 1 0", rn, st, af);
    else passed++;
    total++;
    if (lat !== 6 || rd !== 32'h0080_FF00 || er !== 1'b0) $display("FAIL lw_stall_resp lat=%0d data=%h err=%b want 6 0080ff00 0", lat, rd, er);
    else passed++;
  endtask

  task automatic test_misaligned();
    int lat, rn, wn; logic [31:0] rd, af, wdf; logic er, st, rva; logic [3:0] bef;
    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rn !== 0 || wn !== 0) $display("FAIL lw_misal_bus rd=%0d wr=%0d want 0 0", rn, wn);
    else passed++;
    total++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || rva !== 1'b0) $display("FAIL lw_misal_resp lat=%0d err=%b data=%h next=%b want 1 1 0 0", lat, er, rd, rva);
    else passed++;
    do_req(1'b1, 2'b01, 1'b0, 32'h1, 32'h5, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (lat !== 1 || er !== 1'b1 || wn !== 0) $display("FAIL sh_misal lat=%0d err=%b wr=%0d want 1 1 0", lat, er, wn);
    else passed++;
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (lat !== 1 || er !== 1'b1 || rn !== 0) $display("FAIL size11 lat=%0d err=%b rd=%0d want 1 1 0", lat, er, rn);
    else passed++;
    do_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) $display("FAIL lbu_lane3 lat=%0d err=%b data=%h want 3 0 0", lat, er, rd);
    else passed++;
  endtask

  task automatic test_timeout();
    int lat, rn, wn; logic [31:0] rd, af, wdf; logic er, st, rva; logic [3:0] bef;
    stuck = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    stuck = 1'b0;
    total++;
    if (rn !== 4 || wn !== 0) $display("FAIL timeout_strobes rd=%0d wr=%0d want 4 0", rn, wn);
    else passed++;
    total++;
    if (lat !== 5 || er !== 1'b1 || rd !== 32'h0) $display("FAIL timeout_resp lat=%0d err=%b data=%h want 5 1 0", lat, er, rd);
    else passed++;
  endtask

  task automatic test_reset_mid_bus();
    int lat, rn, wn, w; logic [31:0] rd, af, wdf; logic er, st, rva, got_rv; logic [3:0] bef;
    stuck = 1'b1; got_rv = 1'b0; w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h8; req_signed = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    while (!read && w < 10) begin @(negedge clk); w++; end
    @(negedge clk);
    total++;
    if (read !== 1'b1) $display("FAIL midreset_pre read=%b want 1", read);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (read !== 1'b0 || write !== 1'b0) $display("FAIL midreset_async rd=%b wr=%b want 0 0", read, write);
    else passed++;
    stuck = 1'b0;
    repeat (2) begin @(negedge clk); if (resp_valid) got_rv = 1'b1; end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid) got_rv = 1'b1; end
    total++;
    if (got_rv !== 1'b0) $display("FAIL midreset_noresp resp_valid seen=%b want 0", got_rv);
    else passed++;
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h55, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, er, rn, wn, af, bef, wdf, st, rva);
    total++;
    if (rd !== 32'h0000_5500 || lat !== 3 || er !== 1'b0) $display("FAIL after_reset_lw data=%h lat=%0d err=%b want 00005500 3 0", rd, lat, er);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_loads();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/avalon_mem_master.md
# avalon_mem_master

Upstream bus master for the 8x8192 Avalon-mapped RAM model: turns single CPU load/store requests (byte, half, word; signed/unsigned loads) into one Avalon-MM read or write. It holds the command across `waitrequest` stalls, generates `byteenable` and lane-replicated `writedata`, and returns lane-extracted, extended load data. Sits between the CPU memory stage and the RAM/bus; one transaction in flight at a time.

## Interface
- `WAIT_LIMIT`, default 0: maximum stalled cycles in BUS before abort with error; 0 disables the timeout.
- `clk`  in  1  single system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on a rising edge where `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  valid with `resp_valid`: misaligned/illegal size or timeout.
- `address`  out  32  Avalon address, always word-aligned (`req_addr & ~3`).
- `read`, `write`  out  1 each  Avalon strobes, never both high.
- `waitrequest`  in  1  Avalon stall.
- `writedata`  out  32  lane-replicated store data.
- `byteenable`  out  4  active lanes.
- `readdata`  in  32  Avalon read data.

## Operation
- States: IDLE, BUS, CAPT, RESP.
- IDLE: `req_ready`=1. On an accepted request, register op, size, signed, `addr[1:0]`.
  - Misaligned request goes to RESP with error; no bus activity. Misaligned = half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11.
  - Otherwise goes to BUS.
- BUS: `read` or `write` high. `address`, `writedata` and `byteenable` are registered and stable for the whole state.
  - Rising edge with `waitrequest`=0: a store goes to RESP; a load goes to CAPT.
- CAPT: strobes low. On this state's edge, register the extracted `readdata` (the RAM presents it after the accepting edge). Go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `req_valid` is ignored here.
- Byteenable:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `addr[1]` ? 1100 : 0011.
  - word: 1111.
- Writedata:
  - byte: `{4{wdata[7:0]}}`.
  - half: `{2{wdata[15:0]}}`.
  - word: `wdata`.
- Load extraction is little-endian: lane `k` = `readdata[8k+7:8k]`.
  - byte uses lane `addr[1:0]`.
  - half uses `readdata[16*addr[1]+:16]`.
  - Extend the selected lane(s) to 32 bits per `req_signed`; word loads pass through unchanged.
- Timeout (`WAIT_LIMIT`>0):
  - Counter increments each BUS cycle with `waitrequest`=1 and clears on entry to BUS.
  - When it reaches `WAIT_LIMIT`: drop strobes, go to RESP with `resp_error`=1 and `resp_rdata`=0.

## Timing
- Reset values: `read`, `write`, `resp_valid`, `resp_error` = 0; `address`, `writedata`, `resp_rdata` = 0; `byteenable` = 0; state IDLE.
- `req_ready` is 1 during and after reset, but no request is accepted while `reset`=1.
- Latency from the accepting edge to `resp_valid` high, with zero wait:
  - store: 2 cycles.
  - load: 3 cycles.
  - error: 1 cycle.
  - Each stalled BUS cycle adds 1.
- Strobes rise the cycle after acceptance and fall the cycle after the edge where `waitrequest`=0. They are never reasserted within the same transaction.
- `reset` mid-transaction: strobes drop asynchronously, no response is issued, and the next request is accepted normally.
- Back-to-back requests: minimum one IDLE cycle between transactions.

## Test plan
- SW 0x12345678 to 0x80000010, zero wait:
  - `write`=1 for 1 cycle, `address`=0x80000010, `byteenable`=1111.
  - `resp_valid` 2 cycles after acceptance, `resp_error`=0.
- SB 0xAB to 0x00000003:
  - `byteenable`=1000, `writedata`=0xABABABAB.
  - A following LW of 0x00000000 returns 0xAB000000.
- LB signed from 0x00000002 with that word = 0x0080FF00:
  - `resp_rdata`=0xFFFFFF80; LBU returns 0x00000080.
  - LH signed from 0x00000002 returns 0x00000080.
- LW with `waitrequest` high for 3 cycles:
  - `read` held 4 cycles with stable `address`.
  - `resp_valid` 6 cycles after acceptance with correct data.
- Misaligned LW at 0x00000002:
  - no `read`/`write` pulse.
  - `resp_valid`=`resp_error`=1 one cycle later, `resp_rdata`=0.
- `WAIT_LIMIT`=4 with `waitrequest` stuck high: strobes drop after 4 stalled cycles and `resp_error`=1. Separately, `reset` pulsed mid-BUS: strobes low immediately, no `resp_valid`.
